max_pool_2x2: RTL and testbench
===============================

MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default `OUT_WIDTH, signed width of conv results and pooled data.
REQ-002 SHALL have parameter MAP_W, default 26, conv output map width in samples; even, >= 2.
REQ-003 SHALL have parameter MAP_H, default 26, conv output map height in rows; even, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rstn  input  1  synchronous, active-high reset; asserted = 1.
REQ-006 SHALL have port in_data  input  OUT_WIDTH  signed conv result, raster order.
REQ-007 SHALL have port in_valid  input  1  in_data qualifier; arbitrary gaps allowed.
REQ-008 SHALL have port out_data  output  OUT_WIDTH  signed pooled result.
REQ-009 SHALL have port out_valid  output  1  one-cycle qualifier per pooled sample.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse with the last pooled sample of a frame.

Function
REQ-011 SHALL consume the conv stage result/valid stream directly; no backpressure, every in_valid beat is accepted.
REQ-012 SHALL keep col counter 0..MAP_W-1 and row counter 0..MAP_H-1, advancing only on in_valid; col wraps to 0 and row increments at col = MAP_W-1; row wraps to 0 at the frame's last sample.
REQ-013 SHALL track row parity as a two-state FSM: ROW_EVEN -> ROW_ODD on the last sample of an even row, ROW_ODD -> ROW_EVEN on the last sample of an odd row.
REQ-014 SHALL on even col register in_data into pair_reg.
REQ-015 SHALL on odd col form hmax = signed max(pair_reg, in_data).
REQ-016 SHALL in ROW_EVEN write hmax to line buffer entry col>>1; line buffer depth MAP_W/2.
REQ-017 SHALL in ROW_ODD compute signed max(linebuf[col>>1], hmax) and present it on out_data with out_valid = 1 exactly one cycle after the accepting in_valid edge.
REQ-018 SHALL hold out_data at its last value and drive out_valid = 0 on all other cycles.
REQ-019 SHALL assert frame_done in the same cycle as out_valid for row = MAP_H-1, col = MAP_W-1; never otherwise.
REQ-020 SHALL treat equal operands in every max as don't-care selection (value identical); compare as two's complement, no width growth.
REQ-021 SHALL process back-to-back frames with no idle cycle required between them.

Reset
REQ-022 SHALL, on rstn = 1 at a clock edge, clear col, row, FSM (ROW_EVEN), pair_reg, out_data = 0, out_valid = 0, frame_done = 0.
REQ-023 SHALL not clear line buffer contents; they SHALL be overwritten before use.
REQ-024 SHALL, on reset mid-frame, discard the partial frame; the first in_valid after reset is col 0, row 0 of a new frame.

Configuration
REQ-025 SHALL, with macro POOL_RELU_EN defined, clamp each in_data to 0 when negative before any max (fused ReLU); out_data is then never negative.
REQ-026 SHALL, without POOL_RELU_EN, perform pure signed max pooling on raw in_data.

Structure
REQ-027 SHALL take OUT_WIDTH from the shared define.sv header; package pool_pkg SHALL hold MAP_W/MAP_H defaults, LB_DEPTH = MAP_W/2, and typedef pool_data_t (signed OUT_WIDTH).
REQ-028 SHALL instantiate one sub-module pool_line_buf: 1 write + 1 read port, LB_DEPTH x OUT_WIDTH, registerless combinational read.

Verification (MAP_W = 4, MAP_H = 4)
REQ-029 SHALL check reset: rstn = 1 for 2 cycles with in_valid = 1 -> out_valid = 0, out_data = 0, frame_done = 0 throughout.
REQ-030 SHALL check ramp: inputs 0..15 continuous valid -> out_data 5, 7, 13, 15, each one cycle after inputs 5, 7, 13, 15; frame_done only with 15.
REQ-031 SHALL check negatives: all inputs -3, input 5 = -8 -> four outputs of -3 without POOL_RELU_EN; four outputs of 0 with it.
REQ-032 SHALL check gapped valid: ramp of REQ-030 with in_valid every other cycle -> same four values, same order, one cycle after each accepting beat.
REQ-033 SHALL check mid-frame reset: 6 ramp inputs, reset, then inputs 100..115 -> outputs exactly 105, 107, 113, 115; no stale value.
REQ-034 SHALL check back-to-back frames: two ramps, no gap -> 8 outputs (5, 7, 13, 15 twice), exactly two frame_done pulses.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and default geometry for the 2x2 max-pool stage.
`include "define.sv"
package pool_pkg;
  localparam int unsigned DATA_W    = `OUT_WIDTH;
  localparam int unsigned MAP_W_DEF = 26;
  localparam int unsigned MAP_H_DEF = 26;
  localparam int unsigned LB_DEPTH  = MAP_W_DEF / 2;

  typedef logic signed [DATA_W-1:0] pool_data_t;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;
endpackage

// File: rtl/define.sv
// Shared project-wide defines: conv/pool datapath width.
`ifndef DEFINE_SV
`define DEFINE_SV
`define OUT_WIDTH 16
`endif

// File: rtl/pool_line_buf.sv
// Half-row line buffer: one write port, one combinational read port, no reset.
module pool_line_buf #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 13,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]       raddr,
  output logic signed [WIDTH-1:0] rdata
);
  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-order conv result stream.
// Define POOL_RELU_EN to clamp negative inputs to zero before pooling (fused ReLU).
`include "define.sv"
module max_pool_2x2
  import pool_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = `OUT_WIDTH,
  parameter int unsigned MAP_W     = MAP_W_DEF,
  parameter int unsigned MAP_H     = MAP_H_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [OUT_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic                        frame_done
);
  localparam int unsigned COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int unsigned ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned DEPTH  = MAP_W / 2;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);

  function automatic logic signed [OUT_WIDTH-1:0] smax(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  row_state_e state, state_next;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic signed [OUT_WIDTH-1:0] sample;
  logic signed [OUT_WIDTH-1:0] pair_reg;
  logic signed [OUT_WIDTH-1:0] hmax;
  logic signed [OUT_WIDTH-1:0] lb_rdata;
  logic [ADDR_W-1:0] lb_addr;
  logic last_col, last_row, odd_col, lb_we, emit;

`ifdef POOL_RELU_EN
  assign sample = in_data[OUT_WIDTH-1] ? '0 : in_data;
`else
  assign sample = in_data;
`endif

  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign odd_col  = col[0];
  assign hmax     = smax(pair_reg, sample);
  assign lb_addr  = ADDR_W'(col >> 1);
  assign lb_we    = in_valid && odd_col && (state == ROW_EVEN);
  assign emit     = in_valid && odd_col && (state == ROW_ODD);

  // Row parity state register
  always_ff @(posedge clk) begin
    if (rstn) state <= ROW_EVEN;
    else      state <= state_next;
  end

  // Parity flips on the last accepted sample of each row
  always_comb begin
    state_next = state;
    if (in_valid && last_col) begin
      case (state)
        ROW_EVEN: state_next = ROW_ODD;
        ROW_ODD:  state_next = ROW_EVEN;
        default:  state_next = ROW_EVEN;
      endcase
    end
  end

  // Raster position counters
  always_ff @(posedge clk) begin
    if (rstn) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn)                     pair_reg <= '0;
    else if (in_valid && !odd_col) pair_reg <= sample;
  end

  pool_line_buf #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(hmax),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

  // Pooled output; out_data holds between results
  always_ff @(posedge clk) begin
    if (rstn) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && last_col && last_row;
      if (emit) out_data <= smax(lb_rdata, hmax);
    end
  end
endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed self-checking bench for max_pool_2x2 on a 4x4 map.
module tb_max_pool_2x2;
  import pool_pkg::*;

  localparam int unsigned W = DATA_W;

  logic       clk = 1'b0;
  logic       rstn;
  pool_data_t in_data;
  logic       in_valid;
  pool_data_t out_data;
  logic       out_valid;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_count = 0;
  int last_out = 0;

  max_pool_2x2 #(
    .OUT_WIDTH(W),
    .MAP_W    (4),
    .MAP_H    (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check registered outputs just after posedge
  task automatic step(input bit rst, input bit v, input int d,
                      input bit ev, input int ed, input bit efd, input string tag);
    @(negedge clk);
    rstn     = rst;
    in_valid = v;
    in_data  = W'(d);
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_count++;
    check({tag, ".valid"}, int'(out_valid), int'(ev));
    check({tag, ".data"},  int'(out_data),  ed);
    check({tag, ".done"},  int'(frame_done), int'(efd));
  endtask

  // One 4x4 frame; pooled results land after samples 5, 7, 13, 15
  task automatic run_frame(input int base, input bit neg, input bit gap, input string tag);
    int  val, exp;
    bit  ev;
    for (int i = 0; i < 16; i++) begin
      if (gap) step(1'b0, 1'b0, 0, 1'b0, last_out, 1'b0, {tag, ".gap"});
      if (neg) begin
        val = (i == 5) ? -8 : -3;
`ifdef POOL_RELU_EN
        exp = 0;
`else
        exp = -3;
`endif
      end else begin
        val = base + i;
        exp = base + i;
      end
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      if (ev) last_out = exp;
      step(1'b0, 1'b1, val, ev, last_out, i == 15, tag);
    end
  endtask

  initial begin
    rstn     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset dominates a valid stream
    step(1'b1, 1'b1, 9, 1'b0, 0, 1'b0, "reset0");
    step(1'b1, 1'b1, 9, 1'b0, 0, 1'b0, "reset1");
    last_out = 0;

    fd_count = 0;
    run_frame(0, 1'b0, 1'b0, "ramp");
    check("ramp.fd_count", fd_count, 1);

    run_frame(0, 1'b1, 1'b0, "neg");
    run_frame(0, 1'b0, 1'b1, "gapped");

    // Partial frame then reset; the next frame must start cleanly at col 0, row 0
    for (int i = 0; i < 6; i++) begin
      if (i == 5) last_out = 5;
      step(1'b0, 1'b1, i, i == 5, last_out, 1'b0, "partial");
    end
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, "midreset");
    last_out = 0;
    run_frame(100, 1'b0, 1'b0, "after_rst");

    fd_count = 0;
    run_frame(0, 1'b0, 1'b0, "b2b_a");
    run_frame(0, 1'b0, 1'b0, "b2b_b");
    step(1'b0, 1'b0, 0, 1'b0, last_out, 1'b0, "b2b_idle");
    check("b2b.fd_count", fd_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
